mem_port_arbiter: RTL

- Round-robin arbiter and sequencer that shares the single serial-memory port of the multicore cache system between NUM_REQ per-core miss/writeback requesters.
- Sits between the per-core cache controllers and the mem_req_*/mem_resp_* pins of top.
- Issues one memory transaction at a time.
- Routes each response back to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one serial-memory port
//            between NUM_REQ per-core miss/writeback requesters. One memory
//            transaction is in flight at a time; the completion is routed
//            back to the requester that issued it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n     : clock, synchronous active-low reset
//   req_valid/rw     : per-requester request and type (1=write, 0=read)
//   req_addr/data    : per-requester address/write data, slice i at
//                      [i*W +: W]
//   req_ready        : one-cycle accept pulse, one-hot
//   resp_valid       : one-cycle completion pulse, one-hot
//   resp_data        : read data, held between pulses
//   mem_req_*        : memory request channel (valid/rw/addr/data/ready)
//   mem_resp_*       : memory read response channel
//   grant_id         : index of the current or last granted requester
//   busy             : high whenever a transaction is in progress
//   timeout_err      : sticky response-watchdog error
// Build option
//   MEM_ARB_TIMEOUT_EN : when defined, a WAIT watchdog of TIMEOUT_CYC cycles
//                        completes a stalled read with data 0 and sets
//                        timeout_err. When undefined, WAIT has no bound and
//                        timeout_err is constant 0.
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        mem_req_valid,
    output logic                        mem_req_rw,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [DATA_W-1:0]           mem_req_data,
    input  logic                        mem_req_ready,
    input  logic                        mem_resp_valid,
    input  logic [DATA_W-1:0]           mem_resp_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_one = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    logic [GID_W-1:0]     r_rr_ptr;
    logic [GID_W-1:0]     r_grant;
    logic                 r_rw;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_data;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic [NUM_REQ-1:0]   r_resp_valid;
    logic [DATA_W-1:0]    r_resp_data;

    logic                 w_found;
    logic [GID_W-1:0]     w_sel;
    int                   w_idx;

`ifdef MEM_ARB_TIMEOUT_EN
    // At least one bit so that a degenerate TIMEOUT_CYC still elaborates.
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] c_cnt_limit = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0]     r_wait_cnt;
    logic                 r_timeout_err;
`endif

    // Round-robin pick: first valid requester scanning upward from the one
    // after the last grant, wrapping modulo NUM_REQ. The last grant is visited
    // last, which bounds every requester's wait to NUM_REQ-1 transactions.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = GID_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= GID_W'(NUM_REQ - 1);
            r_grant      <= '0;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            // Accept and completion strobes are single-cycle pulses.
            r_req_ready  <= '0;
            r_resp_valid <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_sel;
                        r_rr_ptr    <= w_sel;
                        r_rw        <= req_rw[w_sel];
                        r_addr      <= req_addr[w_sel*ADDR_W +: ADDR_W];
                        r_data      <= req_data[w_sel*DATA_W +: DATA_W];
                        r_req_ready <= c_one << w_sel;
                        r_state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // mem_resp_valid is deliberately not looked at here, even
                    // on the handshake cycle.
                    if (mem_req_ready) begin
                        if (r_rw) begin
                            r_resp_valid <= c_one << r_grant;
                            r_resp_data  <= '0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end
                    end
                end

                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        // A response on the limit cycle wins over the watchdog.
                        r_resp_valid <= c_one << r_grant;
                        r_resp_data  <= mem_resp_data;
                        r_state      <= ST_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (r_wait_cnt == c_cnt_limit) begin
                        r_resp_valid  <= c_one << r_grant;
                        r_resp_data   <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request channel is only driven while issuing; it reads as zero otherwise.
    assign mem_req_valid = (r_state == ST_ISSUE);
    assign mem_req_rw    = mem_req_valid & r_rw;
    assign mem_req_addr  = mem_req_valid ? r_addr : '0;
    assign mem_req_data  = mem_req_valid ? r_data : '0;

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp_data;
    assign grant_id      = r_grant;
    assign busy          = (r_state != ST_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout_err   = r_timeout_err;
`else
    assign timeout_err   = 1'b0;
`endif

endmodule
`default_nettype wire
